// File: rtl/spi_slave_gen.sv
// rtl/spi_slave_gen.sv - parametrised oversampling SPI slave with write strobe and read handshake
// Optional SPI_SLV_ERR_CNT_EN adds an 8-bit saturating error counter output (err_cnt).

module spi_slave_gen #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_underrun,
  output logic              frame_err
`ifdef SPI_SLV_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, DONE} state_t;

  localparam logic       SCLK_IDLE   = (CPOL != 0);
  localparam bit         SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
  localparam logic [5:0] A_LAST      = 6'(ADDR_W - 1);
  localparam logic [5:0] D_LAST      = 6'(DATA_W - 1);

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;

  state_t              state;
  logic [5:0]          cnt;
  logic                cmd_rd;
  logic [ADDR_W-1:0]   addr_sh, addr_next;
  logic [DATA_W-1:0]   data_sh, data_next;
  logic [DATA_W-1:0]   tx_sh, tx_src;
  logic                tx_loaded, tx_under, tx_bit;
  int                  a_idx, d_idx;

  logic rise, fall, sample_edge, shift_edge, ss_fall;

  // Select syncs reset low so a reset released mid-frame waits for a genuine ss_n high-to-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= SCLK_IDLE;
      sclk_s2 <= SCLK_IDLE;
      sclk_d  <= SCLK_IDLE;
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_d    <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      miso_oe <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ss_s1   <= ss_n;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      miso_oe <= ~ss_s2;
    end
  end

  assign rise        = sclk_s2 & ~sclk_d;
  assign fall        = ~sclk_s2 & sclk_d;
  assign sample_edge = SAMPLE_RISE ? rise : fall;
  assign shift_edge  = SAMPLE_RISE ? fall : rise;
  assign ss_fall     = ss_d & ~ss_s2;

  always_comb begin
    addr_next = addr_sh;
    data_next = data_sh;
    tx_src    = tx_loaded ? tx_sh : tx_data;
    tx_bit    = 1'b0;
    a_idx     = (LSB_FIRST != 0) ? int'(cnt) : ADDR_W - 1 - int'(cnt);
    d_idx     = (LSB_FIRST != 0) ? int'(cnt) : DATA_W - 1 - int'(cnt);
    for (int i = 0; i < ADDR_W; i++)
      if (i == a_idx) addr_next[i] = mosi_s2;
    for (int i = 0; i < DATA_W; i++)
      if (i == d_idx) begin
        data_next[i] = mosi_s2;
        tx_bit       = tx_src[i];
      end
    if (tx_under) tx_bit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_rd      <= 1'b0;
      addr_sh     <= '0;
      data_sh     <= '0;
      tx_sh       <= '0;
      tx_loaded   <= 1'b0;
      tx_under    <= 1'b0;
      miso        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_addr     <= '0;
      rx_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rd_req      <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      if (ss_s2) begin
        if (state inside {CMD, ADDR, WR_DATA, RD_DATA}) frame_err <= 1'b1;
        state <= IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ss_fall) begin
            state     <= CMD;
            cnt       <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            tx_loaded <= 1'b0;
            tx_under  <= 1'b0;
          end
          CMD: if (sample_edge) begin
            cmd_rd <= mosi_s2;
            state  <= ADDR;
            cnt    <= '0;
          end
          ADDR: if (sample_edge) begin
            addr_sh <= addr_next;
            if (cnt == A_LAST) begin
              cnt <= '0;
              if (cmd_rd) begin
                state   <= RD_DATA;
                rd_addr <= addr_next;
                rd_req  <= 1'b1;
              end else begin
                state <= WR_DATA;
              end
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          WR_DATA: if (sample_edge) begin
            data_sh <= data_next;
            if (cnt == D_LAST) begin
              rx_addr  <= addr_sh;
              rx_data  <= data_next;
              rx_valid <= 1'b1;
              state    <= DONE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          RD_DATA: begin
            if (tx_valid && !tx_loaded && !tx_under) begin
              tx_sh     <= tx_data;
              tx_loaded <= 1'b1;
            end
            if (shift_edge) begin
              // A shift edge with nothing loaded and no same-cycle tx_valid commits the frame to zeros.
              if (!tx_loaded && !tx_valid && !tx_under) begin
                tx_under    <= 1'b1;
                tx_underrun <= 1'b1;
                miso        <= 1'b0;
              end else begin
                miso <= tx_bit;
              end
              if (cnt == D_LAST) begin
                state <= DONE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 6'd1;
              end
            end
          end
          DONE: if (shift_edge) miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_SLV_ERR_CNT_EN
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + 9'(frame_err) + 9'(tx_underrun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (ss_fall && err_cnt != 8'd0)
      err_cnt <= '0;
    else
      err_cnt <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// tb/tb_spi_slave_gen.sv - directed bench for spi_slave_gen in modes 0, 3 and 1 (LSB-first, 4/16)

module tb_spi_slave_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi;

  logic sclk_0, ss_n_0, miso_0, miso_oe_0, rx_valid_0, rd_req_0, tx_valid_0, tx_underrun_0, frame_err_0;
  logic [7:0] rx_addr_0, rx_data_0, rd_addr_0, tx_data_0;

  logic sclk_3, ss_n_3, miso_3, miso_oe_3, rx_valid_3, rd_req_3, tx_valid_3, tx_underrun_3, frame_err_3;
  logic [7:0] rx_addr_3, rx_data_3, rd_addr_3, tx_data_3;

  logic sclk_1, ss_n_1, miso_1, miso_oe_1, rx_valid_1, rd_req_1, tx_valid_1, tx_underrun_1, frame_err_1;
  logic [3:0] rx_addr_1, rd_addr_1;
  logic [15:0] rx_data_1, tx_data_1;

`ifdef SPI_SLV_ERR_CNT_EN
  logic [7:0] err_cnt_0, err_cnt_3, err_cnt_1;
`endif

  int checks = 0;
  int failures = 0;

  int n_rx0 = 0, n_rd0 = 0, n_und0 = 0, n_fe0 = 0;
  int n_rx3 = 0, n_rd3 = 0, n_und3 = 0;
  int n_rx1 = 0;

  logic       resp_en_0 = 1'b0, resp_en_3 = 1'b0;
  int         resp_dly_0 = 1, resp_dly_3 = 1;
  logic [7:0] resp_data_0 = '0, resp_data_3 = '0;

  always #5 clk = ~clk;

  spi_slave_gen u_m0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_0), .ss_n(ss_n_0), .mosi(mosi),
    .miso(miso_0), .miso_oe(miso_oe_0), .rx_valid(rx_valid_0), .rx_addr(rx_addr_0),
    .rx_data(rx_data_0), .rd_req(rd_req_0), .rd_addr(rd_addr_0), .tx_valid(tx_valid_0),
    .tx_data(tx_data_0), .tx_underrun(tx_underrun_0), .frame_err(frame_err_0)
`ifdef SPI_SLV_ERR_CNT_EN
    , .err_cnt(err_cnt_0)
`endif
  );

  spi_slave_gen #(.CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_3), .ss_n(ss_n_3), .mosi(mosi),
    .miso(miso_3), .miso_oe(miso_oe_3), .rx_valid(rx_valid_3), .rx_addr(rx_addr_3),
    .rx_data(rx_data_3), .rd_req(rd_req_3), .rd_addr(rd_addr_3), .tx_valid(tx_valid_3),
    .tx_data(tx_data_3), .tx_underrun(tx_underrun_3), .frame_err(frame_err_3)
`ifdef SPI_SLV_ERR_CNT_EN
    , .err_cnt(err_cnt_3)
`endif
  );

  spi_slave_gen #(.ADDR_W(4), .DATA_W(16), .CPOL(0), .CPHA(1), .LSB_FIRST(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_1), .ss_n(ss_n_1), .mosi(mosi),
    .miso(miso_1), .miso_oe(miso_oe_1), .rx_valid(rx_valid_1), .rx_addr(rx_addr_1),
    .rx_data(rx_data_1), .rd_req(rd_req_1), .rd_addr(rd_addr_1), .tx_valid(tx_valid_1),
    .tx_data(tx_data_1), .tx_underrun(tx_underrun_1), .frame_err(frame_err_1)
`ifdef SPI_SLV_ERR_CNT_EN
    , .err_cnt(err_cnt_1)
`endif
  );

  always @(negedge clk) begin
    if (rx_valid_0)    n_rx0  <= n_rx0 + 1;
    if (rd_req_0)      n_rd0  <= n_rd0 + 1;
    if (tx_underrun_0) n_und0 <= n_und0 + 1;
    if (frame_err_0)   n_fe0  <= n_fe0 + 1;
    if (rx_valid_3)    n_rx3  <= n_rx3 + 1;
    if (rd_req_3)      n_rd3  <= n_rd3 + 1;
    if (tx_underrun_3) n_und3 <= n_und3 + 1;
    if (rx_valid_1)    n_rx1  <= n_rx1 + 1;
  end

  initial begin
    tx_valid_0 = 1'b0;
    tx_data_0  = '0;
    forever begin
      @(negedge clk);
      if (rd_req_0 && resp_en_0) begin
        repeat (resp_dly_0) @(posedge clk);
        #1;
        tx_valid_0 = 1'b1;
        tx_data_0  = resp_data_0;
        @(posedge clk);
        #1;
        tx_valid_0 = 1'b0;
      end
    end
  end

  initial begin
    tx_valid_3 = 1'b0;
    tx_data_3  = '0;
    forever begin
      @(negedge clk);
      if (rd_req_3 && resp_en_3) begin
        repeat (resp_dly_3) @(posedge clk);
        #1;
        tx_valid_3 = 1'b1;
        tx_data_3  = resp_data_3;
        @(posedge clk);
        #1;
        tx_valid_3 = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sclk(input int sel, input logic v);
    case (sel)
      0:       sclk_0 = v;
      3:       sclk_3 = v;
      default: sclk_1 = v;
    endcase
  endtask

  task automatic set_ss(input int sel, input logic v);
    case (sel)
      0:       ss_n_0 = v;
      3:       ss_n_3 = v;
      default: ss_n_1 = v;
    endcase
  endtask

  function automatic logic get_miso(input int sel);
    case (sel)
      0:       return miso_0;
      3:       return miso_3;
      default: return miso_1;
    endcase
  endfunction

  task automatic half_period();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input int sel, input int cpol, input int cpha, input int lsb,
                           input int aw, input int dw, input logic rd,
                           input logic [15:0] addr, input logic [31:0] data,
                           input int nbits, output logic [31:0] cap);
    logic b[64];
    logic bit_in;
    int   j;
    cap = '0;
    b[0] = rd;
    for (int k = 0; k < aw; k++) b[1 + k] = (lsb != 0) ? addr[k] : addr[aw - 1 - k];
    for (int k = 0; k < dw; k++) b[1 + aw + k] = (lsb != 0) ? data[k] : data[dw - 1 - k];
    set_ss(sel, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      if (cpha == 0) begin
        mosi = b[i];
        half_period();
        set_sclk(sel, logic'(cpol == 0));
      end else begin
        set_sclk(sel, logic'(cpol == 0));
        mosi = b[i];
        half_period();
      end
      if (cpha != 0) set_sclk(sel, logic'(cpol != 0));
      if (i > aw) begin
        j      = i - 1 - aw;
        bit_in = get_miso(sel);
        if (lsb != 0) cap[j] = bit_in;
        else          cap[dw - 1 - j] = bit_in;
      end
      half_period();
      if (cpha == 0) set_sclk(sel, logic'(cpol != 0));
    end
    half_period();
    set_ss(sel, 1'b1);
    repeat (10) @(posedge clk);
    #1;
  endtask

  logic [31:0] cap;
  int s_rx, s_rd, s_und, s_fe;

  initial begin
    rst_n  = 1'b0;
    mosi   = 1'b0;
    sclk_0 = 1'b0; ss_n_0 = 1'b1;
    sclk_3 = 1'b1; ss_n_3 = 1'b1;
    sclk_1 = 1'b0; ss_n_1 = 1'b1;
    tx_valid_1 = 1'b0;
    tx_data_1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", miso_0, 0);
    chk("rst_miso_oe", miso_oe_0, 0);
    chk("rst_rx_valid", rx_valid_0, 0);
    chk("rst_rd_req", rd_req_0, 0);
    chk("rst_rx_addr", rx_addr_0, 0);
    chk("rst_rx_data", rx_data_0, 0);
    chk("rst_rd_addr", rd_addr_0, 0);
    chk("rst_tx_underrun", tx_underrun_0, 0);
    chk("rst_frame_err", frame_err_0, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Mode 0 write
    s_rx = n_rx0; s_rd = n_rd0; s_fe = n_fe0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b0, 16'h5A, 32'hC3, 17, cap);
    chk("m0_wr_rx_pulses", n_rx0 - s_rx, 1);
    chk("m0_wr_rx_addr", rx_addr_0, 32'h5A);
    chk("m0_wr_rx_data", rx_data_0, 32'hC3);
    chk("m0_wr_rd_pulses", n_rd0 - s_rd, 0);
    chk("m0_wr_frame_err", n_fe0 - s_fe, 0);

    // Mode 3 read, data supplied the cycle after rd_req
    resp_en_3 = 1'b1; resp_dly_3 = 1; resp_data_3 = 8'hA5;
    s_rx = n_rx3; s_rd = n_rd3; s_und = n_und3;
    spi_frame(3, 1, 1, 0, 8, 8, 1'b1, 16'h12, 32'h0, 17, cap);
    chk("m3_rd_req_pulses", n_rd3 - s_rd, 1);
    chk("m3_rd_addr", rd_addr_3, 32'h12);
    chk("m3_rd_capture", cap, 32'hA5);
    chk("m3_rd_underrun", n_und3 - s_und, 0);
    chk("m3_rd_rx_pulses", n_rx3 - s_rx, 0);

    // Mode 1, LSB first, 4-bit address, 16-bit data
    s_rx = n_rx1;
    spi_frame(1, 0, 1, 1, 4, 16, 1'b0, 16'h9, 32'hBEEF, 21, cap);
    chk("m1_wr_rx_pulses", n_rx1 - s_rx, 1);
    chk("m1_wr_rx_addr", rx_addr_1, 32'h9);
    chk("m1_wr_rx_data", rx_data_1, 32'hBEEF);

    // Mode 0 read: CPHA=0 first bit driven on the trailing edge of the last address bit
    resp_en_0 = 1'b1; resp_dly_0 = 1; resp_data_0 = 8'h3C;
    s_rd = n_rd0; s_und = n_und0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b1, 16'h77, 32'h0, 17, cap);
    chk("m0_rd_req_pulses", n_rd0 - s_rd, 1);
    chk("m0_rd_addr", rd_addr_0, 32'h77);
    chk("m0_rd_capture", cap, 32'h3C);
    chk("m0_rd_underrun", n_und0 - s_und, 0);

    // Underrun: tx_valid arrives well after the first shift edge and must be ignored
    resp_dly_0 = 20; resp_data_0 = 8'hFF;
    s_rd = n_rd0; s_und = n_und0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b1, 16'h34, 32'h0, 17, cap);
    chk("und_rd_req_pulses", n_rd0 - s_rd, 1);
    chk("und_pulses", n_und0 - s_und, 1);
    chk("und_capture", cap, 32'h00);

    // Abort a write after 5 data bits, then a clean frame
    s_rx = n_rx0; s_fe = n_fe0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b0, 16'h66, 32'h99, 14, cap);
    chk("abort_frame_err", n_fe0 - s_fe, 1);
    chk("abort_rx_pulses", n_rx0 - s_rx, 0);
    chk("abort_rx_data_held", rx_data_0, 32'hC3);
    s_rx = n_rx0; s_fe = n_fe0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b0, 16'h21, 32'h84, 17, cap);
    chk("post_abort_rx_pulses", n_rx0 - s_rx, 1);
    chk("post_abort_rx_addr", rx_addr_0, 32'h21);
    chk("post_abort_rx_data", rx_data_0, 32'h84);
    chk("post_abort_frame_err", n_fe0 - s_fe, 0);

    // Asynchronous reset in the middle of a read data phase
    resp_dly_0 = 1; resp_data_0 = 8'hFF;
    fork
      spi_frame(0, 0, 0, 0, 8, 8, 1'b1, 16'h4B, 32'h0, 17, cap);
      begin
        repeat (130) @(posedge clk);
        #2;
        chk("pre_rst_miso", miso_0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", miso_0, 0);
        chk("mid_rst_miso_oe", miso_oe_0, 0);
        chk("mid_rst_rd_addr", rd_addr_0, 0);
        chk("mid_rst_rx_addr", rx_addr_0, 0);
        chk("mid_rst_rx_data", rx_data_0, 0);
        chk("mid_rst_rd_req", rd_req_0, 0);
        #3;
        rst_n = 1'b1;
        s_fe = n_fe0; s_rx = n_rx0;
      end
    join
    chk("rst_resync_frame_err", n_fe0 - s_fe, 0);
    chk("rst_resync_rx_pulses", n_rx0 - s_rx, 0);
    s_rx = n_rx0;
    spi_frame(0, 0, 0, 0, 8, 8, 1'b0, 16'h0F, 32'hF0, 17, cap);
    chk("post_rst_rx_pulses", n_rx0 - s_rx, 1);
    chk("post_rst_rx_addr", rx_addr_0, 32'h0F);
    chk("post_rst_rx_data", rx_data_0, 32'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
